// File: rtl/gemm_pkg.sv
// Shared definitions for the GeMM accelerator and its operand loader.
//   ADDR_WIDTH      : default width of matrix sizes and SRAM addresses
//   DATA_WIDTH      : default element width
//   loader_state_e  : operand loader FSM states
package gemm_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        DONE   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/gemm_matrix_walker.sv
// Row-major matrix walker: steps a (row, col) pair and a linear address
// through a rows x cols matrix, one element per advance.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : return to (0,0) / address 0 (wins over advance_i)
//   advance_i    : step to the next element
//   rows_i       : number of rows in the current matrix
//   cols_i       : number of columns in the current matrix
//   addr_o       : linear address of the current element (wraps mod 2^AddrWidth)
//   last_o       : current element is (rows-1, cols-1)
module gemm_matrix_walker
    import gemm_pkg::*;
#(
    parameter int AddrWidth = ADDR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 advance_i,
    input  logic [AddrWidth-1:0] rows_i,
    input  logic [AddrWidth-1:0] cols_i,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 last_o
);

    localparam logic [AddrWidth-1:0] One = AddrWidth'(1);

    logic [AddrWidth-1:0] row_reg, row_next;
    logic [AddrWidth-1:0] col_reg, col_next;
    logic [AddrWidth-1:0] addr_reg, addr_next;
    logic                 row_last;
    logic                 col_last;

    assign row_last = (row_reg == rows_i - One);
    assign col_last = (col_reg == cols_i - One);

    always_comb begin
        row_next  = row_reg;
        col_next  = col_reg;
        addr_next = addr_reg;
        if (clear_i) begin
            row_next  = '0;
            col_next  = '0;
            addr_next = '0;
        end else if (advance_i) begin
            addr_next = addr_reg + One;
            if (col_last) begin
                col_next = '0;
                row_next = row_reg + One;
            end else begin
                col_next = col_reg + One;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_reg  <= '0;
            col_reg  <= '0;
            addr_reg <= '0;
        end else begin
            row_reg  <= row_next;
            col_reg  <= col_next;
            addr_reg <= addr_next;
        end
    end

    assign addr_o = addr_reg;
    assign last_o = row_last & col_last;

endmodule

// File: rtl/gemm_operand_loader.sv
// Streaming operand loader for the GeMM accelerator. Takes a valid/ready
// byte stream holding A (MxK) then B (KxN), both row-major, and writes
// them to SRAM A / SRAM B at m*K+k and k*N+n. Pulses gemm_start_o (with
// done_o) once both matrices are resident.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   start_i                   : begin a load (only honoured in IDLE)
//   M_size_i/K_size_i/N_size_i: matrix dimensions, latched at start
//   s_data_i/s_valid_i/s_ready_o : input element stream
//   sram_a_* / sram_b_*       : SRAM write ports (zero-latency writes)
//   busy_o                    : load in progress (LOAD_A, LOAD_B, DONE)
//   done_o, gemm_start_o      : one-cycle completion / accelerator start
module gemm_operand_loader
    import gemm_pkg::*;
#(
    parameter int AddrWidth = ADDR_WIDTH,
    parameter int DataWidth = DATA_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] K_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic [DataWidth-1:0] s_data_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    output logic [AddrWidth-1:0] sram_a_addr_o,
    output logic [DataWidth-1:0] sram_a_wdata_o,
    output logic                 sram_a_we_o,
    output logic [AddrWidth-1:0] sram_b_addr_o,
    output logic [DataWidth-1:0] sram_b_wdata_o,
    output logic                 sram_b_we_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 gemm_start_o
);

    loader_state_e        state_reg;
    logic [AddrWidth-1:0] m_reg, k_reg, n_reg;
    logic                 ready_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic                 transfer;
    logic                 walk_clear;
    logic                 walk_last;
    logic [AddrWidth-1:0] walk_rows;
    logic [AddrWidth-1:0] walk_cols;
    logic [AddrWidth-1:0] walk_addr;
    logic                 size_zero;
    logic [1:0]           we_vec;

    // Ready comes from a register only, so it never depends on s_valid_i.
    assign transfer  = s_valid_i & ready_reg;
    assign size_zero = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);

    // One walker serves both phases: A is MxK, B is KxN.
    assign walk_rows  = (state_reg == LOAD_B) ? k_reg : m_reg;
    assign walk_cols  = (state_reg == LOAD_B) ? n_reg : k_reg;
    assign walk_clear = ((state_reg == IDLE) && start_i) || (transfer && walk_last);

    gemm_matrix_walker #(
        .AddrWidth (AddrWidth)
    ) u_walker (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (walk_clear),
        .advance_i (transfer),
        .rows_i    (walk_rows),
        .cols_i    (walk_cols),
        .addr_o    (walk_addr),
        .last_o    (walk_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            k_reg     <= '0;
            n_reg     <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        m_reg    <= M_size_i;
                        k_reg    <= K_size_i;
                        n_reg    <= N_size_i;
                        busy_reg <= 1'b1;
                        if (size_zero) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= LOAD_A;
                            ready_reg <= 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    // Ready stays high into LOAD_B: no bubble at the switch.
                    if (transfer && walk_last) begin
                        state_reg <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (transfer && walk_last) begin
                        state_reg <= DONE;
                        ready_reg <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Write enable per SRAM port: port 0 is A, port 1 is B.
    for (genvar gi = 0; gi < 2; gi++) begin : g_wport
        localparam loader_state_e PhaseState = (gi == 0) ? LOAD_A : LOAD_B;
        assign we_vec[gi] = transfer && (state_reg == PhaseState);
    end

    assign s_ready_o      = ready_reg;
    assign sram_a_we_o    = we_vec[0];
    assign sram_b_we_o    = we_vec[1];
    assign sram_a_addr_o  = walk_addr;
    assign sram_b_addr_o  = walk_addr;
    assign sram_a_wdata_o = s_data_i;
    assign sram_b_wdata_o = s_data_i;
    assign busy_o         = busy_reg;
    assign done_o         = done_reg;
    assign gemm_start_o   = done_reg;

endmodule

// File: tb/tb_gemm_operand_loader.sv
module tb_gemm_operand_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] M_size_i, K_size_i, N_size_i;
    logic [7:0]  s_data_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [15:0] sram_a_addr_o, sram_b_addr_o;
    logic [7:0]  sram_a_wdata_o, sram_b_wdata_o;
    logic        sram_a_we_o, sram_b_we_o;
    logic        busy_o, done_o, gemm_start_o;

    gemm_operand_loader dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .M_size_i       (M_size_i),
        .K_size_i       (K_size_i),
        .N_size_i       (N_size_i),
        .s_data_i       (s_data_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .sram_a_addr_o  (sram_a_addr_o),
        .sram_a_wdata_o (sram_a_wdata_o),
        .sram_a_we_o    (sram_a_we_o),
        .sram_b_addr_o  (sram_b_addr_o),
        .sram_b_wdata_o (sram_b_wdata_o),
        .sram_b_we_o    (sram_b_we_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .gemm_start_o   (gemm_start_o)
    );

    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: a load is just a count of accepted elements; the
    // first M*K go to A at address n, the rest go to B at address n-M*K.
    int mode = 0;          // 0 idle, 1 loading, 2 done cycle
    int n_acc = 0;
    int mdl_mk = 0;
    int mdl_tot = 0;
    bit xfer;

    // Bench-side image of what the DUT wrote, plus event bookkeeping.
    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];
    int wa_cnt = 0, wb_cnt = 0, done_cnt = 0;
    int done_cyc = -1, wa_cyc = -1, wb_cyc = -1;
    int start_cyc = 0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            mode  = 0;
            n_acc = 0;
            chk("rst_ready", s_ready_o, 0);
            chk("rst_we_a", sram_a_we_o, 0);
            chk("rst_we_b", sram_b_we_o, 0);
            chk("rst_addr_a", sram_a_addr_o, 0);
            chk("rst_addr_b", sram_b_addr_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_gstart", gemm_start_o, 0);
        end else begin
            xfer = (mode == 1) && s_valid_i;
            chk("ready", s_ready_o, int'(mode == 1));
            chk("busy", busy_o, int'(mode != 0));
            chk("done", done_o, int'(mode == 2));
            chk("gemm_start", gemm_start_o, int'(mode == 2));
            chk("we_a", sram_a_we_o, int'(xfer && n_acc < mdl_mk));
            chk("we_b", sram_b_we_o, int'(xfer && n_acc >= mdl_mk));
            if (xfer && n_acc < mdl_mk) begin
                chk("addr_a", sram_a_addr_o, n_acc % 65536);
                chk("wdata_a", sram_a_wdata_o, s_data_i);
            end
            if (xfer && n_acc >= mdl_mk) begin
                chk("addr_b", sram_b_addr_o, (n_acc - mdl_mk) % 65536);
                chk("wdata_b", sram_b_wdata_o, s_data_i);
            end
            // model step for the coming edge
            if (mode == 0) begin
                if (start_i) begin
                    mdl_mk  = int'(M_size_i) * int'(K_size_i);
                    mdl_tot = mdl_mk + int'(K_size_i) * int'(N_size_i);
                    n_acc   = 0;
                    mode    = (M_size_i == 0 || K_size_i == 0 || N_size_i == 0) ? 2 : 1;
                end
            end else if (mode == 1) begin
                if (xfer) begin
                    n_acc++;
                    if (n_acc == mdl_tot) mode = 2;
                end
            end else begin
                mode = 0;
            end
        end
        if (sram_a_we_o === 1'b1) begin
            mem_a[sram_a_addr_o[5:0]] = sram_a_wdata_o;
            wa_cnt++;
            wa_cyc = cyc;
        end
        if (sram_b_we_o === 1'b1) begin
            mem_b[sram_b_addr_o[5:0]] = sram_b_wdata_o;
            wb_cnt++;
            wb_cyc = cyc;
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 8'hEE;
            mem_b[i] = 8'hEE;
        end
    endtask

    task automatic do_start(input int m, input int k, input int n);
        M_size_i  = 16'(m);
        K_size_i  = 16'(k);
        N_size_i  = 16'(n);
        start_i   = 1'b1;
        start_cyc = cyc;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Streams elements 1,2,3,... until 'total' are accepted. With gap set,
    // valid is only offered on every other cycle. When poke_at >= 0, start_i
    // is raised (with different sizes) while element poke_at is pending.
    task automatic stream(input int total, input bit gap, input int poke_at);
        int  sent = 0;
        int  c    = 0;
        bit  acc;
        while (sent < total && c < 400) begin
            s_valid_i = gap ? (c % 2 == 0) : 1'b1;
            s_data_i  = 8'(sent + 1);
            if (sent == poke_at) begin
                start_i  = 1'b1;
                M_size_i = 16'd7;
                K_size_i = 16'd7;
                N_size_i = 16'd7;
            end else begin
                start_i = 1'b0;
            end
            acc = s_valid_i && s_ready_o;
            @(posedge clk_i);
            #1;
            if (acc) sent++;
            c++;
        end
        s_valid_i = 1'b0;
        start_i   = 1'b0;
        chk("stream_accepted", sent, total);
    endtask

    int d0, wa0, wb0;

    task automatic snap();
        d0  = done_cnt;
        wa0 = wa_cnt;
        wb0 = wb_cnt;
    endtask

    initial begin
        rst_i     = 1'b1;
        start_i   = 1'b0;
        M_size_i  = '0;
        K_size_i  = '0;
        N_size_i  = '0;
        s_data_i  = '0;
        s_valid_i = 1'b0;
        clear_mem();
        #1;
        chk("por_ready", s_ready_o, 0);
        chk("por_busy", busy_o, 0);
        idle(2);
        rst_i = 1'b0;
        idle(2);

        // 1) 2x3 * 3x2, continuous stream
        clear_mem();
        snap();
        do_start(2, 3, 2);
        stream(12, 1'b0, -1);
        idle(2);
        for (int i = 0; i < 6; i++) chk($sformatf("t1_mem_a[%0d]", i), mem_a[i], i + 1);
        for (int i = 0; i < 6; i++) chk($sformatf("t1_mem_b[%0d]", i), mem_b[i], i + 7);
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_done_cycle", done_cyc - start_cyc, 13);
        chk("t1_writes_a", wa_cnt - wa0, 6);
        chk("t1_writes_b", wb_cnt - wb0, 6);
        $display("t1 continuous 2x3x2: done at start+%0d", done_cyc - start_cyc);

        // 2) same sizes, valid on every other cycle
        clear_mem();
        snap();
        do_start(2, 3, 2);
        stream(12, 1'b1, -1);
        idle(2);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_mem_a[%0d]", i), mem_a[i], i + 1);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_mem_b[%0d]", i), mem_b[i], i + 7);
        chk("t2_done_pulses", done_cnt - d0, 1);
        chk("t2_done_cycle", done_cyc - start_cyc, 24);
        chk("t2_writes", (wa_cnt - wa0) + (wb_cnt - wb0), 12);
        $display("t2 stalled 2x3x2: done at start+%0d", done_cyc - start_cyc);

        // 3) zero-size start with valid held high
        snap();
        s_valid_i = 1'b1;
        s_data_i  = 8'h5A;
        do_start(0, 4, 4);
        idle(3);
        s_valid_i = 1'b0;
        chk("t3_writes", (wa_cnt - wa0) + (wb_cnt - wb0), 0);
        chk("t3_done_pulses", done_cnt - d0, 1);
        chk("t3_done_cycle", done_cyc - start_cyc, 1);
        $display("t3 zero-size: done at start+%0d", done_cyc - start_cyc);

        // 4) 1x1x1, then again immediately after DONE
        for (int r = 0; r < 2; r++) begin
            clear_mem();
            snap();
            do_start(1, 1, 1);
            stream(2, 1'b0, -1);
            idle(1);
            chk("t4_mem_a0", mem_a[0], 1);
            chk("t4_mem_b0", mem_b[0], 2);
            chk("t4_b_after_a", wb_cyc - wa_cyc, 1);
            chk("t4_done_cycle", done_cyc - start_cyc, 3);
            chk("t4_done_pulses", done_cnt - d0, 1);
            $display("t4 1x1x1 run %0d: done at start+%0d", r, done_cyc - start_cyc);
        end

        // 5) start_i (and new sizes) during LOAD_B are ignored
        idle(1);
        clear_mem();
        snap();
        do_start(2, 3, 2);
        stream(12, 1'b0, 7);
        idle(2);
        for (int i = 0; i < 6; i++) chk($sformatf("t5_mem_b[%0d]", i), mem_b[i], i + 7);
        chk("t5_done_pulses", done_cnt - d0, 1);
        chk("t5_done_cycle", done_cyc - start_cyc, 13);
        $display("t5 start in LOAD_B: done at start+%0d", done_cyc - start_cyc);

        // 6) reset after 3 of 6 A transfers, then a fresh 2x2x2 load
        snap();
        do_start(2, 3, 2);
        stream(3, 1'b0, -1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("t6_async_ready", s_ready_o, 0);
        chk("t6_async_busy", busy_o, 0);
        chk("t6_async_addr_a", sram_a_addr_o, 0);
        chk("t6_async_we_a", sram_a_we_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(2);
        chk("t6_no_done", done_cnt - d0, 0);
        clear_mem();
        snap();
        do_start(2, 2, 2);
        stream(8, 1'b0, -1);
        idle(2);
        for (int i = 0; i < 4; i++) chk($sformatf("t6_mem_a[%0d]", i), mem_a[i], i + 1);
        for (int i = 0; i < 4; i++) chk($sformatf("t6_mem_b[%0d]", i), mem_b[i], i + 5);
        chk("t6_done_pulses", done_cnt - d0, 1);
        $display("t6 reset mid-load then 2x2x2: done at start+%0d", done_cyc - start_cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
